vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output. It produces the `row`/`col` pixel coordinates consumed by the chaos-map pixel renderers, then registers their combinational `red`/`green`/`blue` answer together with `hsync`/`vsync`, so all pin outputs leave aligned. It also emits a one-cycle `frame_start` pulse that the map iterators use as a per-frame restart and parameter-update strobe.

## Interface
Parameters:
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BACK`, 48: horizontal back porch (line total 800)
- `V_VISIBLE`, 480: active lines
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BACK`, 33: vertical back porch (frame total 525)

Ports:
- `CLK`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `RST`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel tick (1 of every 2 clocks at 50 MHz). All state advances only when high.
- `row`  out  10  vertical counter `v_cnt`, 0..524, combinational from the register.
- `col`  out  10  horizontal counter `h_cnt`, 0..799, combinational from the register.
- `visible`  out  1  `h_cnt < H_VISIBLE && v_cnt < V_VISIBLE`, combinational.
- `red`, `green`, `blue`  in  1 each  renderer colour for the current (`row`, `col`).
- `frame_start`  out  1  registered one-clock pulse at frame wrap.
- `hsync`, `vsync`  out  1 each  registered, active-low.
- `vga_r`, `vga_g`, `vga_b`  out  1 each  registered, blanked colour.

## Operation
- **Horizontal phase FSM** (decoded from `h_cnt`):
  - VISIBLE: 0..639
  - FRONT: 640..655
  - SYNC: 656..751
  - BACK: 752..799
  - BACK wraps to VISIBLE.
- **Vertical phase FSM** (decoded from `v_cnt`):
  - VISIBLE: 0..479
  - FRONT: 480..489
  - SYNC: 490..491
  - BACK: 492..524
- **Counter advance** on a `pix_en` cycle:
  - `h_cnt` increments, wrapping 799 -> 0.
  - On that wrap `v_cnt` increments, wrapping 524 -> 0.
  - Neither counter ever leaves its range.
- **Output capture** on the same `pix_en` edge, from the pre-advance counters:
  - `hsync` <= 0 iff the horizontal phase is SYNC.
  - `vsync` <= 0 iff the vertical phase is SYNC.
  - `{vga_r, vga_g, vga_b}` <= `visible ? {red, green, blue} : 3'b000`.
- **frame_start**: asserted for exactly one clock, following the `pix_en` edge on which the counters move from (799, 524) to (0, 0). It is low on every other clock.
- **pix_en low**: counters and output registers hold, and `frame_start` is 0.
- **Reset**, asynchronous, applied mid-frame or at any time. Values while held:
  - `h_cnt` = `v_cnt` = 0, so `row` = `col` = 0 and `visible` = 1.
  - `hsync` = `vsync` = 1.
  - `vga_*` = 0 and `frame_start` = 0.
- **Reset release**: the first `pix_en` edge captures the outputs for pixel (0, 0). No `frame_start` is emitted on reset exit.

## Timing
- Counter-to-pin latency: one `pix_en` tick. Pins show the pixel whose coordinates were on `row`/`col` at the previous `pix_en` edge.
- Sync and colour are always mutually aligned.
- `red`/`green`/`blue` must settle within one clock of a `row`/`col` change. The renderer path is combinational.
- Line period: 800 `pix_en` ticks.
- Frame period: 420 000 ticks (840 000 clocks at 1:2 enable).
- `hsync` low for 96 ticks per line; `vsync` low for 2 lines (1600 ticks) per frame.
- `frame_start` pulses are exactly 840 000 clocks apart at 1:2 enable.

## Structure
- **Shared package** `vga_pkg`:
  - the eight default timing constants;
  - the `h_phase`/`v_phase` enum (VISIBLE, FRONT, SYNC, BACK);
  - derived totals `H_TOTAL` = 800 and `V_TOTAL` = 525.
- **Sub-module** `vga_axis_counter`, instantiated twice:
  - parameterized by VISIBLE/FRONT/SYNC/BACK;
  - inputs `CLK`, `RST`, `inc`; outputs `cnt`, `wrap`, `phase`;
  - the horizontal `wrap` drives the vertical `inc`.
- The top level holds only the output registers, blanking and `frame_start`.

## Test plan
- **Reset mid-frame**: assert `RST`=0 at `h_cnt` = 300, `v_cnt` = 200.
  - Immediately: `row` = `col` = 0, `hsync` = `vsync` = 1, `vga_*` = 0.
  - After release plus one `pix_en`: `col` = 1.
- **Line timing**, free run at 1:2 enable, measured in `pix_en` ticks per line:
  - `hsync` falls 657 ticks after `col` = 0 is first presented;
  - it stays low for 96 ticks;
  - its period is 800.
- **Frame timing**:
  - `vsync` low for exactly 1600 ticks, starting on the line after `row` = 489;
  - `frame_start` pulses are 420 000 ticks apart;
  - each pulse is 1 clock wide.
- **Blanking**: drive `red`=`green`=`blue`=1 constantly.
  - `vga_*` = 3'b111 for exactly 640 x 480 ticks per frame.
  - `vga_*` = 0 elsewhere, including `col` = 640 and `row` = 480.
- **pix_en stall**: hold `pix_en`=0 for 37 clocks at `col` = 799, `row` = 524.
  - Everything holds and `frame_start` stays 0.
  - The next `pix_en` gives `row` = `col` = 0, then `frame_start` = 1 for one clock.
- **Alignment**: the renderer drives colour = `col[2:0]`; at each pin update, `vga_*` equals the previous `col[2:0]` during the visible region.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing constants, phase type and phase decode
package vga_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef enum logic [1:0] {PH_VISIBLE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

   // Anything past the sync window is back porch; the counter never exceeds its total.
   function automatic phase_t phase_of(input logic [CNT_W-1:0] cnt, input int visible,
                                       input int front, input int sync);
      int c;
      c = int'(cnt);
      if (c < visible)
         return PH_VISIBLE;
      else if (c < visible + front)
         return PH_FRONT;
      else if (c < visible + front + sync)
         return PH_SYNC;
      else
         return PH_BACK;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with phase decode
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = DEF_H_VISIBLE,
   parameter int FRONT   = DEF_H_FRONT,
   parameter int SYNC    = DEF_H_SYNC,
   parameter int BACK    = DEF_H_BACK
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output phase_t           phase
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(VISIBLE + FRONT + SYNC + BACK - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (inc)
         cnt_d = (cnt_q >= LAST) ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      cnt   = cnt_q;
      wrap  = inc && (cnt_q >= LAST);
      phase = phase_of(cnt_q, VISIBLE, FRONT, SYNC);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing with registered, aligned sync and colour pins
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pix_en,
   output logic [CNT_W-1:0] row,
   output logic [CNT_W-1:0] col,
   output logic             visible,
   input  logic             red,
   input  logic             green,
   input  logic             blue,
   output logic             frame_start,
   output logic             hsync,
   output logic             vsync,
   output logic             vga_r,
   output logic             vga_g,
   output logic             vga_b
);

   logic   h_wrap;
   logic   v_wrap;
   phase_t h_phase;
   phase_t v_phase;

   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_cnt (
      .CLK(CLK), .RST(RST), .inc(pix_en), .cnt(col), .wrap(h_wrap), .phase(h_phase)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v_cnt (
      .CLK(CLK), .RST(RST), .inc(h_wrap), .cnt(row), .wrap(v_wrap), .phase(v_phase)
   );

   assign visible = (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);

   // Pins capture the pre-advance pixel so sync and colour stay one tick behind row/col together.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hsync                 <= 1'b1;
         vsync                 <= 1'b1;
         {vga_r, vga_g, vga_b} <= 3'b000;
         frame_start           <= 1'b0;
      end else begin
         frame_start <= v_wrap;
         if (pix_en) begin
            hsync                 <= (h_phase != PH_SYNC);
            vsync                 <= (v_phase != PH_SYNC);
            {vga_r, vga_g, vga_b} <= visible ? {red, green, blue} : 3'b000;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: full-size line timing plus reduced-size frame checks
module tb_vga_timing_gen;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Instance A: default 640x480 timing.
   logic       rst_a, en_a, ones_a;
   logic [2:0] rgb_a;
   logic [9:0] row_a, col_a;
   logic       vis_a, fs_a, hs_a, vs_a, vr_a, vg_a, vb_a;
   assign rgb_a = ones_a ? 3'b111 : col_a[2:0];

   vga_timing_gen dut_a (
      .CLK(CLK), .RST(rst_a), .pix_en(en_a), .row(row_a), .col(col_a), .visible(vis_a),
      .red(rgb_a[2]), .green(rgb_a[1]), .blue(rgb_a[0]), .frame_start(fs_a),
      .hsync(hs_a), .vsync(vs_a), .vga_r(vr_a), .vga_g(vg_a), .vga_b(vb_a)
   );

   // Instance B: 40 x 15 raster (20/4/6/10, 8/2/2/3) so whole frames fit the run.
   logic       rst_b, en_b;
   logic [9:0] row_b, col_b;
   logic       vis_b, fs_b, hs_b, vs_b, vr_b, vg_b, vb_b;

   vga_timing_gen #(
      .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(10),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_b (
      .CLK(CLK), .RST(rst_b), .pix_en(en_b), .row(row_b), .col(col_b), .visible(vis_b),
      .red(1'b1), .green(1'b1), .blue(1'b1), .frame_start(fs_b),
      .hsync(hs_b), .vsync(vs_b), .vga_r(vr_b), .vga_g(vg_b), .vga_b(vb_b)
   );

   int fs_a_cnt = 0;
   int fs_b_n = 0, fs_b_wide = 0, tick_b_n = 0;
   int fs_b_cyc[$];
   int fs_b_tick[$];

   task automatic tick_a();
      en_a = 1'b1;
      @(posedge CLK); #1;
      en_a = 1'b0;
      if (fs_a) fs_a_cnt++;
      @(posedge CLK); #1;
      if (fs_a) fs_a_cnt++;
   endtask

   task automatic tick_b();
      en_b = 1'b1;
      @(posedge CLK); #1;
      en_b = 1'b0;
      tick_b_n++;
      if (fs_b) begin
         fs_b_n++;
         fs_b_cyc.push_back(cyc);
         fs_b_tick.push_back(tick_b_n);
      end
      @(posedge CLK); #1;
      if (fs_b) fs_b_wide++;
   endtask

   initial begin
      int fall1, fall2, nlow, n7, nalign, nvs_a, prev_hs, prev_vs;
      int n7b, nvsl, win, guard, hold_err;
      logic [9:0] pcol, prow, s_row, s_col;
      logic       pvis;
      logic [4:0] s_pins;

      rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0; ones_a = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check_eq("a_rst_row", int'(row_a), 0);
      check_eq("a_rst_col", int'(col_a), 0);
      check_eq("a_rst_visible", int'(vis_a), 1);
      check_eq("a_rst_hsync", int'(hs_a), 1);
      check_eq("a_rst_vsync", int'(vs_a), 1);
      check_eq("a_rst_rgb", int'({vr_a, vg_a, vb_a}), 0);
      check_eq("a_rst_fs", int'(fs_a), 0);

      rst_a = 1'b1;
      @(posedge CLK); #1;
      check_eq("a_idle_col", int'(col_a), 0);

      // Line 1 all-white (blanking, hsync placement); line 2 colour = col[2:0] (alignment).
      fall1 = -1; fall2 = -1; nlow = 0; n7 = 0; nalign = 0; nvs_a = 0; prev_hs = 1;
      for (int k = 1; k <= 1600; k++) begin
         ones_a = (k <= 800);
         pcol = col_a;
         pvis = vis_a;
         tick_a();
         if (k == 1) begin
            check_eq("a_first_col", int'(col_a), 1);
            check_eq("a_first_rgb", int'({vr_a, vg_a, vb_a}), 7);
         end
         if (hs_a == 1'b0 && prev_hs == 1) begin
            if (fall1 < 0) fall1 = k;
            else if (fall2 < 0) fall2 = k;
         end
         if (!vs_a) nvs_a++;
         if (k <= 800) begin
            if ({vr_a, vg_a, vb_a} == 3'b111) n7++;
            if (!hs_a) nlow++;
            if (k == 641) check_eq("a_col640_blank", int'({vr_a, vg_a, vb_a}), 0);
         end else if ({vr_a, vg_a, vb_a} != (pvis ? pcol[2:0] : 3'b000)) begin
            nalign++;
         end
         prev_hs = int'(hs_a);
      end
      check_eq("a_hsync_fall_tick", fall1, 657);
      check_eq("a_hsync_period", fall2 - fall1, 800);
      check_eq("a_hsync_low_ticks", nlow, 96);
      check_eq("a_visible_ticks_line", n7, 640);
      check_eq("a_align_errors", nalign, 0);
      check_eq("a_row_after_2_lines", int'(row_a), 2);
      check_eq("a_col_after_2_lines", int'(col_a), 0);
      check_eq("a_vsync_low_ticks", nvs_a, 0);
      check_eq("a_fs_count", fs_a_cnt, 0);

      // B: run into the sync corner (row 10, col 26) then reset asynchronously.
      rst_b = 1'b1;
      repeat (426) tick_b();
      check_eq("b_pre_rst_col", int'(col_b), 26);
      check_eq("b_pre_rst_row", int'(row_b), 10);
      check_eq("b_pre_rst_hsync", int'(hs_b), 0);
      check_eq("b_pre_rst_vsync", int'(vs_b), 0);
      #2 rst_b = 1'b0;
      #1;
      check_eq("b_rst_row", int'(row_b), 0);
      check_eq("b_rst_col", int'(col_b), 0);
      check_eq("b_rst_hsync", int'(hs_b), 1);
      check_eq("b_rst_vsync", int'(vs_b), 1);
      check_eq("b_rst_rgb", int'({vr_b, vg_b, vb_b}), 0);
      check_eq("b_rst_visible", int'(vis_b), 1);
      @(posedge CLK); #1;
      rst_b = 1'b1;
      fs_b_n = 0; fs_b_wide = 0; tick_b_n = 0;
      fs_b_cyc.delete();
      fs_b_tick.delete();
      tick_b();
      check_eq("b_release_col", int'(col_b), 1);
      check_eq("b_release_rgb", int'({vr_b, vg_b, vb_b}), 7);
      check_eq("b_release_fs", fs_b_n, 0);

      // Frame window: ticks after the first frame_start up to and including the second.
      n7b = 0; nvsl = 0; prev_vs = 1;
      for (int k = 0; k < 1300; k++) begin
         prow = row_b;
         pcol = col_b;
         win = (fs_b_n == 1);
         tick_b();
         if (win) begin
            if ({vr_b, vg_b, vb_b} == 3'b111) n7b++;
            if (!vs_b) nvsl++;
            if (vs_b == 1'b0 && prev_vs == 1) begin
               check_eq("b_vsync_fall_row", int'(prow), 10);
               check_eq("b_vsync_fall_col", int'(pcol), 0);
            end
            if (prow == 10'd8 && pcol == 10'd0)
               check_eq("b_row8_blank", int'({vr_b, vg_b, vb_b}), 0);
         end
         prev_vs = int'(vs_b);
      end
      check_eq("b_fs_count", fs_b_n, 2);
      if (fs_b_cyc.size() >= 2) begin
         check_eq("b_fs_first_tick", fs_b_tick[0], 600);
         check_eq("b_fs_tick_spacing", fs_b_tick[1] - fs_b_tick[0], 600);
         check_eq("b_fs_clk_spacing", fs_b_cyc[1] - fs_b_cyc[0], 1200);
      end
      check_eq("b_fs_wide", fs_b_wide, 0);
      check_eq("b_visible_ticks_frame", n7b, 160);
      check_eq("b_vsync_low_ticks", nvsl, 80);

      // Stall at the last pixel of the frame.
      guard = 0;
      while (!(row_b == 10'd14 && col_b == 10'd39) && guard < 700) begin
         tick_b();
         guard++;
      end
      check_eq("b_stall_reach", int'(row_b == 10'd14 && col_b == 10'd39), 1);
      s_row = row_b; s_col = col_b;
      s_pins = {hs_b, vs_b, vr_b, vg_b, vb_b};
      hold_err = 0;
      repeat (37) begin
         @(posedge CLK); #1;
         if (row_b != s_row || col_b != s_col || fs_b ||
             {hs_b, vs_b, vr_b, vg_b, vb_b} != s_pins)
            hold_err++;
      end
      check_eq("b_stall_hold_errors", hold_err, 0);
      en_b = 1'b1;
      @(posedge CLK); #1;
      en_b = 1'b0;
      check_eq("b_wrap_row", int'(row_b), 0);
      check_eq("b_wrap_col", int'(col_b), 0);
      check_eq("b_wrap_fs", int'(fs_b), 1);
      check_eq("b_wrap_pins", int'({hs_b, vs_b, vr_b, vg_b, vb_b}), 5'b11000);
      @(posedge CLK); #1;
      check_eq("b_wrap_fs_drop", int'(fs_b), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
